l2_denorm_stream: RTL



---
 rtl/l2_denorm_stream.sv | 131 +++++++++++++
 1 files changed

// File: rtl/l2_denorm_stream.sv
// Rescales a stream of unit-norm Q2.30 elements by a per-frame Q16.16 norm word.
// Define L2DENORM_ROUND_EN for round-half-away-from-zero; default build truncates toward -inf.
module l2_denorm_stream #(
  parameter int unsigned VEC_LEN   = 16,
  parameter int unsigned ELEM_FRAC = 30,
  parameter int unsigned NORM_FRAC = 16,
  parameter int unsigned OUT_FRAC  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] input_data,
  output logic        valid_out,
  output logic [31:0] output_data,
  output logic        last_out,
  output logic        sat_out
);

  localparam int unsigned SHIFT = ELEM_FRAC + NORM_FRAC - OUT_FRAC;
  localparam logic signed [64:0] OUT_MAX = 65'sd2147483647;
  localparam logic signed [64:0] OUT_MIN = -65'sd2147483648;

  typedef enum logic {S_NORM, S_ELEM} state_t;

  state_t      state;
  logic [15:0] elem_cnt;
  logic [31:0] norm_reg;

  logic elem_fire;
  logic elem_last;

  assign elem_fire = valid_in && (state == S_ELEM);
  assign elem_last = (elem_cnt == 16'(VEC_LEN - 1));

  // Frame sequencer: the first valid beat of a frame is the norm, the next VEC_LEN are elements.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_NORM;
      elem_cnt <= '0;
      norm_reg <= '0;
    end else if (valid_in) begin
      case (state)
        S_NORM: begin
          norm_reg <= input_data;
          elem_cnt <= '0;
          state    <= S_ELEM;
        end
        S_ELEM: begin
          if (elem_last) begin
            elem_cnt <= '0;
            state    <= S_NORM;
          end else begin
            elem_cnt <= elem_cnt + 16'd1;
          end
        end
        default: state <= S_NORM;
      endcase
    end
  end

  // Stage 1: signed element times zero-extended norm; 65 bits hold the full product exactly.
  logic signed [64:0] elem_ext;
  logic signed [64:0] norm_ext;
  logic signed [64:0] s1_prod;
  logic               s1_valid;
  logic               s1_last;

  assign elem_ext = 65'(signed'(input_data));
  assign norm_ext = {33'd0, norm_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
    end else begin
      s1_valid <= elem_fire;
      s1_last  <= elem_fire && elem_last;
      if (elem_fire) s1_prod <= elem_ext * norm_ext;
    end
  end

  // Stage 2: rescale to the output format, then clamp to signed 32-bit.
  logic signed [64:0] shifted;
  logic [31:0]        sat_data;
  logic               sat_flag;

`ifdef L2DENORM_ROUND_EN
  logic        prod_neg;
  logic [64:0] mag;
  logic [64:0] mag_rnd;

  always_comb begin
    prod_neg = s1_prod[64];
    mag      = prod_neg ? 65'(-s1_prod) : 65'(s1_prod);
    mag_rnd  = mag + (65'd1 << (SHIFT - 1));
    shifted  = prod_neg ? -$signed(mag_rnd >> SHIFT) : $signed(mag_rnd >> SHIFT);
  end
`else
  assign shifted = s1_prod >>> SHIFT;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sat_data = shifted[31:0];
    sat_flag = 1'b0;
    if (shifted > OUT_MAX) begin
      sat_data = 32'h7FFF_FFFF;
      sat_flag = 1'b1;
    end else if (shifted < OUT_MIN) begin
      sat_data = 32'h8000_0000;
      sat_flag = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out   <= 1'b0;
      output_data <= '0;
      last_out    <= 1'b0;
      sat_out     <= 1'b0;
    end else begin
      valid_out <= s1_valid;
      last_out  <= s1_valid && s1_last;
      sat_out   <= s1_valid && sat_flag;
      if (s1_valid) output_data <= sat_data;
    end
  end

endmodule
